// File: rtl/nibble_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nibble_cpu_sequencer
// Description : Fetch/execute sequencer for the 4-bit microcoded CPU.
//               Owns the program counter, the fetch/execute phase bit, the
//               fetched-instruction register, the C/Z flags and a saturating
//               retired-instruction counter. It forms the microcode ROM
//               address {opcode, C, Z, phase}, consumes the 13-bit control
//               word returned in the same cycle, and issues per-step strobes
//               to the datapath.
//
// Ports       :
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   en           in   run enable; 0 freezes all state
//   prog_byte    in   program byte at pc: [7:4] opcode, [3:0] operand
//   prog_valid   in   prog_byte valid for the current pc
//   ctrl_word    in   microcode word for rom_addr (combinational ROM)
//   jump_addr    in   jump target from the datapath
//   alu_c/alu_z  in   ALU carry / zero results
//   rom_addr     out  {opcode, c_flag, z_flag, phase}
//   pc           out  program address
//   phase        out  0 = fetch, 1 = execute
//   operand      out  fetched operand nibble
//   c_flag/z_flag out registered flags
//   step         out  this cycle advances the machine
//   load_a, cs_ram, we_ram, oe_alu, oe_in, oe_oprnd, load_out
//                out  control-word bits gated by step
//   alu_sel      out  control-word ALU select, ungated
//   instr_count  out  retired instructions, saturating
//
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_cpu_sequencer #(
    parameter int PC_W  = 12,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [7:0]       prog_byte,
    input  logic             prog_valid,
    input  logic [12:0]      ctrl_word,
    input  logic [PC_W-1:0]  jump_addr,
    input  logic             alu_c,
    input  logic             alu_z,
    output logic [6:0]       rom_addr,
    output logic [PC_W-1:0]  pc,
    output logic             phase,
    output logic [3:0]       operand,
    output logic             c_flag,
    output logic             z_flag,
    output logic             step,
    output logic             load_a,
    output logic [2:0]       alu_sel,
    output logic             cs_ram,
    output logic             we_ram,
    output logic             oe_alu,
    output logic             oe_in,
    output logic             oe_oprnd,
    output logic             load_out,
    output logic [CNT_W-1:0] instr_count
);

    // ------------------------------------------------------------------------
    // Phase state encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_fetch   = 1'b0;
    localparam logic [0:0] c_execute = 1'b1;

    // Control word field positions
    localparam int c_inc_pc     = 12;
    localparam int c_load_pc    = 11;
    localparam int c_load_a     = 10;
    localparam int c_load_flags = 9;
    localparam int c_cs_ram     = 5;
    localparam int c_we_ram     = 4;
    localparam int c_oe_alu     = 3;
    localparam int c_oe_in      = 2;
    localparam int c_oe_oprnd   = 1;
    localparam int c_load_out   = 0;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [PC_W-1:0]  r_pc;
    logic [7:0]       r_instr;
    logic             r_c_flag;
    logic             r_z_flag;
    logic [CNT_W-1:0] r_instr_count;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [0:0]       w_state_nxt;
    logic             w_step;
    logic             w_inc_pc;
    logic             w_load_pc;
    logic             w_load_flags;

    // ------------------------------------------------------------------------
    // Phase state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_fetch;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and strobe decode
    //
    // Fetch stalls until the program byte is valid; execute always advances.
    // reset is folded into step so that no strobe can leak out while the
    // machine is held in reset (the ROM may still be presenting a fetch word).
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_step       = 1'b0;
        w_inc_pc     = 1'b0;
        w_load_pc    = 1'b0;
        w_load_flags = 1'b0;
        load_a       = 1'b0;
        cs_ram       = 1'b0;
        we_ram       = 1'b0;
        oe_alu       = 1'b0;
        oe_in        = 1'b0;
        oe_oprnd     = 1'b0;
        load_out     = 1'b0;

        w_step = reset & en & ((r_state == c_execute) | prog_valid);

        case (r_state)
            c_fetch: begin
                if (w_step) begin
                    w_state_nxt = c_execute;
                end
            end
            c_execute: begin
                if (w_step) begin
                    w_state_nxt = c_fetch;
                end
            end
            default: begin
                w_state_nxt = c_fetch;
            end
        endcase

        w_inc_pc     = ctrl_word[c_inc_pc]     & w_step;
        w_load_pc    = ctrl_word[c_load_pc]    & w_step;
        w_load_flags = ctrl_word[c_load_flags] & w_step;
        load_a       = ctrl_word[c_load_a]     & w_step;
        cs_ram       = ctrl_word[c_cs_ram]     & w_step;
        we_ram       = ctrl_word[c_we_ram]     & w_step;
        oe_alu       = ctrl_word[c_oe_alu]     & w_step;
        oe_in        = ctrl_word[c_oe_in]      & w_step;
        oe_oprnd     = ctrl_word[c_oe_oprnd]   & w_step;
        load_out     = ctrl_word[c_load_out]   & w_step;
    end

    // ------------------------------------------------------------------------
    // Program counter: jump wins over increment; increment wraps naturally.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc <= '0;
        end else if (w_load_pc) begin
            r_pc <= jump_addr;
        end else if (w_inc_pc) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Instruction register: captured on the fetch->execute edge. During the
    // following fetch it still holds the previous opcode, which is harmless
    // because the microcode returns the fetch word for every phase-0 address.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instr <= '0;
        end else if (w_step && (r_state == c_fetch)) begin
            r_instr <= prog_byte;
        end
    end

    // ------------------------------------------------------------------------
    // Flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_c_flag <= 1'b0;
            r_z_flag <= 1'b0;
        end else if (w_load_flags) begin
            r_c_flag <= alu_c;
            r_z_flag <= alu_z;
        end
    end

    // ------------------------------------------------------------------------
    // Retired-instruction counter: an instruction retires on the
    // execute->fetch edge. Saturates rather than wrapping so that long runs
    // never read back as a small count.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instr_count <= '0;
        end else if (w_step && (r_state == c_execute) && (r_instr_count != '1)) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rom_addr    = {r_instr[7:4], r_c_flag, r_z_flag, r_state};
    assign pc          = r_pc;
    assign phase       = r_state;
    assign operand     = r_instr[3:0];
    assign c_flag      = r_c_flag;
    assign z_flag      = r_z_flag;
    assign step        = w_step;
    assign alu_sel     = ctrl_word[8:6];
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_nibble_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_cpu_sequencer
// Description : Directed self-checking bench for nibble_cpu_sequencer. The
//               bench plays the role of program memory and microcode ROM;
//               expected values are queued as stimulus is applied and popped
//               when the corresponding DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_cpu_sequencer;

    localparam int PC_W  = 12;
    localparam int CNT_W = 16;

    logic             clock;
    logic             reset;
    logic             en;
    logic [7:0]       prog_byte;
    logic             prog_valid;
    logic [12:0]      ctrl_word;
    logic [PC_W-1:0]  jump_addr;
    logic             alu_c;
    logic             alu_z;
    logic [6:0]       rom_addr;
    logic [PC_W-1:0]  pc;
    logic             phase;
    logic [3:0]       operand;
    logic             c_flag;
    logic             z_flag;
    logic             step;
    logic             load_a;
    logic [2:0]       alu_sel;
    logic             cs_ram;
    logic             we_ram;
    logic             oe_alu;
    logic             oe_in;
    logic             oe_oprnd;
    logic             load_out;
    logic [CNT_W-1:0] instr_count;

    nibble_cpu_sequencer #(
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .prog_byte   (prog_byte),
        .prog_valid  (prog_valid),
        .ctrl_word   (ctrl_word),
        .jump_addr   (jump_addr),
        .alu_c       (alu_c),
        .alu_z       (alu_z),
        .rom_addr    (rom_addr),
        .pc          (pc),
        .phase       (phase),
        .operand     (operand),
        .c_flag      (c_flag),
        .z_flag      (z_flag),
        .step        (step),
        .load_a      (load_a),
        .alu_sel     (alu_sel),
        .cs_ram      (cs_ram),
        .we_ram      (we_ram),
        .oe_alu      (oe_alu),
        .oe_in       (oe_in),
        .oe_oprnd    (oe_oprnd),
        .load_out    (load_out),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write pulses seen at clock edges.
    int wr_pulses = 0;
    always @(posedge clock) begin
        if (we_ram) wr_pulses <= wr_pulses + 1;
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // At most one bus driver enable per cycle.
    task automatic single_driver_check();
        int n;
        n = 32'(oe_alu) + 32'(oe_in) + 32'(oe_oprnd);
        checks++;
        assert (n <= 1) else begin
            errors++;
            $error("FAIL single_driver observed=%0d expected=<=1", n);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        single_driver_check();
    endtask

    int wr_base;

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        en         = 1'b1;
        prog_valid = 1'b1;
        prog_byte  = 8'h2A;
        ctrl_word  = 13'h1008;
        jump_addr  = '0;
        alu_c      = 1'b0;
        alu_z      = 1'b0;
        #2;

        // Reset state; strobes suppressed even though the ROM word has oe_alu.
        push("rst_pc", 32'h0);      chk(32'(pc));
        push("rst_phase", 32'h0);   chk(32'(phase));
        push("rst_c", 32'h0);       chk(32'(c_flag));
        push("rst_z", 32'h0);       chk(32'(z_flag));
        push("rst_count", 32'h0);   chk(32'(instr_count));
        push("rst_step", 32'h0);    chk(32'(step));
        push("rst_oe_alu", 32'h0);  chk(32'(oe_alu));
        tick();
        tick();

        // Release reset in fetch with a valid byte.
        reset = 1'b1;
        #1;
        push("fetch_step", 32'h1);   chk(32'(step));
        push("fetch_oe_alu", 32'h1); chk(32'(oe_alu));
        tick();
        push("f1_phase", 32'h1);     chk(32'(phase));
        push("f1_operand", 32'hA);   chk(32'(operand));
        push("f1_pc", 32'h1);        chk(32'(pc));
        push("f1_rom_addr", 32'h11); chk(32'(rom_addr));

        // Execute a no-op word; instruction retires.
        ctrl_word = 13'h0000;
        tick();
        push("x1_phase", 32'h0);     chk(32'(phase));
        push("x1_count", 32'h1);     chk(32'(instr_count));
        push("x1_pc", 32'h1);        chk(32'(pc));

        // Stalled fetch for three cycles.
        prog_valid = 1'b0;
        prog_byte  = 8'h35;
        ctrl_word  = 13'h1008;
        for (int i = 0; i < 3; i++) begin
            #1;
            push("stall_step", 32'h0);     chk(32'(step));
            push("stall_oe_alu", 32'h0);   chk(32'(oe_alu));
            push("stall_rom_addr", 32'h10); chk(32'(rom_addr));
            tick();
            push("stall_pc", 32'h1);       chk(32'(pc));
            push("stall_phase", 32'h0);    chk(32'(phase));
        end
        prog_valid = 1'b1;
        tick();
        push("f2_phase", 32'h1);     chk(32'(phase));
        push("f2_pc", 32'h2);        chk(32'(pc));
        push("f2_operand", 32'h5);   chk(32'(operand));

        // Execute load_a + load_flags + we_ram, alu_sel=1.
        ctrl_word = 13'h0650;
        alu_c     = 1'b1;
        alu_z     = 1'b0;
        #1;
        push("x2_load_a", 32'h1);    chk(32'(load_a));
        push("x2_we_ram", 32'h1);    chk(32'(we_ram));
        push("x2_alu_sel", 32'h1);   chk(32'(alu_sel));
        push("x2_load_out", 32'h0);  chk(32'(load_out));
        tick();
        ctrl_word = 13'h1008;
        prog_byte = 8'h40;
        alu_c     = 1'b0;
        #1;
        push("x2_c", 32'h1);         chk(32'(c_flag));
        push("x2_z", 32'h0);         chk(32'(z_flag));
        push("x2_load_a_off", 32'h0); chk(32'(load_a));
        push("x2_count", 32'h2);     chk(32'(instr_count));
        push("x2_pc", 32'h2);        chk(32'(pc));

        // Fetch opcode 4 with C set.
        tick();
        push("f3_pc", 32'h3);        chk(32'(pc));
        push("f3_rom_addr", 32'h25); chk(32'(rom_addr));

        // Jump beats increment.
        ctrl_word = 13'h1800;
        jump_addr = 12'h3C4;
        tick();
        push("jmp_pc", 32'h3C4);     chk(32'(pc));
        push("jmp_count", 32'h3);    chk(32'(instr_count));

        // Jump to 0xFFF during fetch, then increment wraps to 0.
        ctrl_word = 13'h0800;
        jump_addr = 12'hFFF;
        prog_byte = 8'h5F;
        tick();
        push("pre_wrap_pc", 32'hFFF); chk(32'(pc));
        ctrl_word = 13'h1000;
        tick();
        push("wrap_pc", 32'h0);      chk(32'(pc));
        push("wrap_count", 32'h4);   chk(32'(instr_count));

        // Enter execute at pc 1, then freeze with en=0 and a write word.
        ctrl_word = 13'h1008;
        tick();
        en        = 1'b0;
        ctrl_word = 13'h0010;
        wr_base   = wr_pulses;
        #1;
        push("en0_we_ram", 32'h0);   chk(32'(we_ram));
        push("en0_step", 32'h0);     chk(32'(step));
        tick();
        tick();
        push("en0_phase", 32'h1);    chk(32'(phase));
        push("en0_pc", 32'h1);       chk(32'(pc));
        push("en0_count", 32'h4);    chk(32'(instr_count));
        en = 1'b1;
        #1;
        push("en1_we_ram", 32'h1);   chk(32'(we_ram));
        tick();
        ctrl_word = 13'h0A00;
        jump_addr = 12'h055;
        alu_c     = 1'b1;
        alu_z     = 1'b1;
        #1;
        push("en1_phase", 32'h0);    chk(32'(phase));
        push("en1_count", 32'h5);    chk(32'(instr_count));

        // Fetch loads pc=0x055 and sets both flags.
        tick();
        push("wr_once", 32'h1);      chk(32'(wr_pulses - wr_base));
        push("pre_rst_pc", 32'h55);  chk(32'(pc));
        push("pre_rst_c", 32'h1);    chk(32'(c_flag));
        push("pre_rst_z", 32'h1);    chk(32'(z_flag));
        push("pre_rst_phase", 32'h1); chk(32'(phase));

        // Asynchronous reset mid-execute, checked before the next edge.
        ctrl_word = 13'h0010;
        #2;
        reset = 1'b0;
        #1;
        push("arst_pc", 32'h0);      chk(32'(pc));
        push("arst_c", 32'h0);       chk(32'(c_flag));
        push("arst_z", 32'h0);       chk(32'(z_flag));
        push("arst_phase", 32'h0);   chk(32'(phase));
        push("arst_count", 32'h0);   chk(32'(instr_count));
        push("arst_we_ram", 32'h0);  chk(32'(we_ram));
        #1;
        reset      = 1'b1;
        ctrl_word  = 13'h1008;
        prog_byte  = 8'h2A;
        prog_valid = 1'b1;
        tick();
        push("post_rst_pc", 32'h1);   chk(32'(pc));
        push("post_rst_phase", 32'h1); chk(32'(phase));
        push("post_rst_operand", 32'hA); chk(32'(operand));

        push("sb_drained", 32'h0);   chk(32'(sb.size() - 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
